// File: rtl/line_clear_engine.sv
// line_clear_engine: after a piece locks, finds full rows in the 10x20 board,
// blinks them through the flash mask, then collapses the board downward.
module line_clear_engine #(
  parameter int unsigned BLINK_CYCLES = 6250000,
  parameter int unsigned BLINK_COUNT  = 3
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         start,
  input  logic [199:0] board_in,
  output logic [199:0] board_out,
  output logic [199:0] flash,
  output logic         busy,
  output logic         done,
  output logic [4:0]   lines_cleared
);

  localparam int unsigned ROWS   = 20;
  localparam int unsigned COLS   = 10;
  localparam int unsigned BITS   = ROWS * COLS;
  localparam int unsigned HALF_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned BLNK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_BLINK    = 3'd2,
    ST_COLLAPSE = 3'd3,
    ST_FILL     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     board_q, board_d;
  logic [BITS-1:0]     flash_q, flash_d;
  logic [ROWS-1:0]     full_mask_q, full_mask_d;
  logic [4:0]          rd_ptr_q, rd_ptr_d;
  logic [5:0]          wr_ptr_q, wr_ptr_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic [BLNK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [4:0]          lines_q, lines_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [7:0]          rd_base_c;
  logic [7:0]          wr_base_c;
  logic                row_full_c;
  logic [ROWS-1:0]     scan_mask_c;
  logic [BITS-1:0]     scan_flash_c;
  logic [BITS-1:0]     held_flash_c;

  // Bit offsets of the read and write rows within the board vector
  assign rd_base_c   = 8'(rd_ptr_q) * 8'(COLS);
  assign wr_base_c   = 8'(wr_ptr_q[4:0]) * 8'(COLS);
  assign row_full_c  = &board_q[rd_base_c +: COLS];
  assign scan_mask_c = full_mask_q | (ROWS'(row_full_c) << rd_ptr_q);

  // Row mask expanded to per-cell flash bits
  for (genvar r = 0; r < ROWS; r++) begin : g_expand
    assign scan_flash_c[r*COLS +: COLS] = {COLS{scan_mask_c[r]}};
    assign held_flash_c[r*COLS +: COLS] = {COLS{full_mask_q[r]}};
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      flash_q     <= '0;
      full_mask_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      half_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      lines_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      flash_q     <= flash_d;
      full_mask_q <= full_mask_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      half_cnt_q  <= half_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      lines_q     <= lines_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    flash_d     = flash_q;
    full_mask_d = full_mask_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    half_cnt_d  = half_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    lines_d     = lines_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        flash_d = '0;
        if (start) begin
          board_d     = board_in;
          full_mask_d = '0;
          rd_ptr_d    = '0;
          lines_d     = '0;
          busy_d      = 1'b1;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        full_mask_d = scan_mask_c;
        if (row_full_c) begin
          lines_d = lines_q + 5'd1;
        end
        if (rd_ptr_q == 5'(ROWS - 1)) begin
          if (scan_mask_c == '0) begin
            state_d = ST_DONE;
          end else begin
            flash_d     = scan_flash_c;
            phase_d     = 1'b1;
            half_cnt_d  = '0;
            blink_cnt_d = '0;
            state_d     = ST_BLINK;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + 5'd1;
        end
      end

      ST_BLINK: begin
        if (half_cnt_q == HALF_W'(BLINK_CYCLES - 1)) begin
          half_cnt_d = '0;
          if (phase_q) begin
            flash_d = '0;
            phase_d = 1'b0;
          end else if (blink_cnt_q == BLNK_W'(BLINK_COUNT - 1)) begin
            rd_ptr_d = 5'(ROWS - 1);
            wr_ptr_d = 6'(ROWS - 1);
            state_d  = ST_COLLAPSE;
          end else begin
            blink_cnt_d = blink_cnt_q + BLNK_W'(1);
            flash_d     = held_flash_c;
            phase_d     = 1'b1;
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end

      // Writer never passes the reader, so in-place copy is safe
      ST_COLLAPSE: begin
        if (!full_mask_q[rd_ptr_q]) begin
          board_d[wr_base_c +: COLS] = board_q[rd_base_c +: COLS];
          wr_ptr_d = wr_ptr_q - 6'd1;
        end
        if (rd_ptr_q == 5'd0) begin
          state_d = wr_ptr_d[5] ? ST_DONE : ST_FILL;
        end else begin
          rd_ptr_d = rd_ptr_q - 5'd1;
        end
      end

      ST_FILL: begin
        if (wr_ptr_q[5]) begin
          state_d = ST_DONE;
        end else begin
          board_d[wr_base_c +: COLS] = '0;
          wr_ptr_d = wr_ptr_q - 6'd1;
          if (wr_ptr_q == 6'd0) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign board_out     = board_q;
  assign flash         = flash_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed testbench for line_clear_engine with short blink timing.
module tb_line_clear_engine;

  localparam int unsigned BCY = 4;
  localparam int unsigned BCN = 2;

  logic         clk = 1'b0;
  logic         clrn;
  logic         start;
  logic [199:0] board_in;
  logic [199:0] board_out;
  logic [199:0] flash;
  logic         busy;
  logic         done;
  logic [4:0]   lines_cleared;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_clear_engine #(
    .BLINK_CYCLES(BCY),
    .BLINK_COUNT (BCN)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .start        (start),
    .board_in     (board_in),
    .board_out    (board_out),
    .flash        (flash),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared)
  );

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] expand(input logic [19:0] m);
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 200; i++) v[8'(i)] = m[5'(i / 10)];
    return v;
  endfunction

  function automatic logic [199:0] set_row(input logic [199:0] b, input int r, input logic [9:0] val);
    logic [199:0] v;
    v = b;
    for (int c = 0; c < 10; c++) v[8'(r * 10 + c)] = val[4'(c)];
    return v;
  endfunction

  // Flash seen at the falling edge after n rising edges since the start edge
  function automatic logic [199:0] exp_flash(input int n, input logic [19:0] m);
    int t;
    t = n - 20;
    if (m != '0 && t >= 0 && t < int'(2 * BCN * BCY) && ((t / int'(BCY)) % 2) == 0)
      return expand(m);
    return '0;
  endfunction

  task automatic run_clear(input logic [199:0] b, input logic [19:0] m,
                           input int restart_at, input logic [199:0] b2,
                           output int cyc, output int flash_bad, output int busy_bad);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 0;
    flash_bad = 0;
    busy_bad  = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (flash !== exp_flash(cyc, m)) flash_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (cyc == restart_at) begin
        board_in = b2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  logic [199:0] b3, b4, exp4, ones;
  int cyc, fbad, bbad, extra;

  initial begin
    clrn     = 1'b0;
    start    = 1'b0;
    board_in = '0;
    repeat (2) @(negedge clk);
    check("rst_board", board_out, '0);
    check("rst_flash", flash, '0);
    check("rst_busy", 200'(busy), '0);
    check("rst_done", 200'(done), '0);
    check("rst_lines", 200'(lines_cleared), '0);
    clrn = 1'b1;

    // Empty board: no blink, done 21 edges after start
    run_clear('0, '0, -1, '0, cyc, fbad, bbad);
    check("empty_latency", 200'(cyc), 200'(21));
    check("empty_lines", 200'(lines_cleared), '0);
    check("empty_flash", 200'(fbad), '0);
    check("empty_busy", 200'(bbad), '0);
    check("empty_board", board_out, '0);
    check("empty_busy_at_done", 200'(busy), '0);
    @(negedge clk);
    check("empty_done_pulse", 200'(done), '0);

    // Row 19 full, row 18 has only column 0
    b3 = set_row('0, 19, 10'h3FF);
    b3 = set_row(b3, 18, 10'h001);
    run_clear(b3, 20'h80000, -1, '0, cyc, fbad, bbad);
    check("one_latency", 200'(cyc), 200'(58));
    check("one_lines", 200'(lines_cleared), 200'(1));
    check("one_flash", 200'(fbad), '0);
    check("one_busy", 200'(bbad), '0);
    check("one_board", board_out, set_row('0, 19, 10'h001));

    // Rows 19,17,16,14 full with patterned rows 18 and 15 between them
    b4 = '0;
    b4 = set_row(b4, 19, 10'h3FF);
    b4 = set_row(b4, 18, 10'h155);
    b4 = set_row(b4, 17, 10'h3FF);
    b4 = set_row(b4, 16, 10'h3FF);
    b4 = set_row(b4, 15, 10'h155);
    b4 = set_row(b4, 14, 10'h3FF);
    exp4 = set_row('0, 19, 10'h155);
    exp4 = set_row(exp4, 18, 10'h155);
    run_clear(b4, 20'hB4000, -1, '0, cyc, fbad, bbad);
    check("four_latency", 200'(cyc), 200'(61));
    check("four_lines", 200'(lines_cleared), 200'(4));
    check("four_flash", 200'(fbad), '0);
    check("four_board", board_out, exp4);

    // Full board: every row clears, FILL runs 20 rows
    ones = '1;
    run_clear(ones, 20'hFFFFF, -1, '0, cyc, fbad, bbad);
    check("all_latency", 200'(cyc), 200'(77));
    check("all_lines", 200'(lines_cleared), 200'(20));
    check("all_flash", 200'(fbad), '0);
    check("all_board", board_out, '0);

    // Second start while busy must be ignored
    run_clear(b3, 20'h80000, 5, ones, cyc, fbad, bbad);
    check("ign_latency", 200'(cyc), 200'(58));
    check("ign_lines", 200'(lines_cleared), 200'(1));
    check("ign_board", board_out, set_row('0, 19, 10'h001));
    extra = 0;
    board_in = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("ign_single_done", 200'(extra), '0);

    // Reset in the middle of BLINK, then restart immediately
    @(negedge clk);
    board_in = b3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("mid_flash_on", flash, expand(20'h80000));
    #2 clrn = 1'b0;
    #1;
    check("mid_rst_board", board_out, '0);
    check("mid_rst_flash", flash, '0);
    check("mid_rst_busy", 200'(busy), '0);
    check("mid_rst_lines", 200'(lines_cleared), '0);
    @(negedge clk);
    clrn     = 1'b1;
    board_in = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_restart_busy", 200'(busy), 200'(1));
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_restart_latency", 200'(cyc), 200'(21));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Game-side producer of the board bitmap and flash mask consumed by the VGA display path.
- After a piece locks, the block latches the settled board and finds full rows.
- It blinks the full rows through the flash mask, then collapses the remaining rows downward.
- It outputs the updated 10x20 objectMatrix and a done pulse with the cleared-line count.

Parameters:
- BLINK_CYCLES, 6250000, clk cycles per blink half-period (0.25 s at 25 MHz); must be >= 1.
- BLINK_COUNT, 3, number of on/off blink pairs before collapse; must be >= 1.

Ports:
- clk  input  1  system clock (25 MHz).
- clrn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latch board_in and begin a clear cycle.
- board_in  input  200  settled board; bit row*10+col; row 0 top, row 19 bottom; 1 = occupied.
- board_out  output  200  registered objectMatrix for the display; same bit mapping.
- flash  output  200  registered flash mask; same bit mapping.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a clear cycle.
- lines_cleared  output  5  number of full rows removed (0-20); holds until the next accepted start.

Behaviour:
- Reset (clrn=0, async): state IDLE; board_out, flash, lines_cleared, row mask, counters all 0; busy=0, done=0.
- Internal regs: full_mask[19:0], rd_ptr[4:0], wr_ptr[5:0] (signed, -1 = exhausted), blink_cnt, half_cnt, phase.
- Assert-on-reset-release is not required; reset mid-operation discards all work and returns to IDLE with cleared outputs.
- States:
  - IDLE:
    - busy=0.
    - start=1: board_out<=board_in, full_mask<=0, rd_ptr<=0, lines_cleared<=0; go to SCAN.
    - start is ignored in every state other than IDLE.
  - SCAN:
    - One row per cycle, rd_ptr 0..19.
    - full_mask[rd_ptr]<=&board_out[row]; lines_cleared increments when the row is full.
    - Exactly 20 cycles.
    - Then: if no row is full, go to DONE; else go to BLINK with flash<=rows of full_mask set to all-ones, phase=on, counters=0.
  - BLINK:
    - half_cnt counts to BLINK_CYCLES-1, then toggles flash between the full-row mask and 0.
    - Each off->on transition counts one blink.
    - After BLINK_COUNT complete on/off pairs (flash ends at 0), go to COLLAPSE with rd_ptr=19, wr_ptr=19.
    - board_out is unchanged during BLINK; full rows stay visible under flash.
  - COLLAPSE:
    - One cycle per rd_ptr from 19 down to 0.
    - If full_mask[rd_ptr]=0: row wr_ptr<=row rd_ptr, wr_ptr decrements.
    - A full row is skipped.
    - Exactly 20 cycles, then go to FILL.
  - FILL:
    - While wr_ptr >= 0: row wr_ptr<=0, wr_ptr decrements; one row per cycle.
    - Takes lines_cleared cycles; 0 cycles when wr_ptr is already -1.
    - Then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle; go to IDLE.
- In-place copy is safe because wr_ptr >= rd_ptr always holds, so no source row is overwritten before it is read.
- busy=1 in SCAN, BLINK, COLLAPSE and FILL.
- Latency from start (no full rows): done asserts 1+20 cycles later.
- Latency from start (n full rows): done asserts 1+20+2*BLINK_COUNT*BLINK_CYCLES+20+n cycles later.
- flash is 0 in every state except BLINK.
- board_in is sampled only on an accepted start; later changes have no effect.

Test Plan:
- Reset mid-BLINK (BLINK_CYCLES=4, BLINK_COUNT=2): assert clrn low -> all outputs 0 immediately; after release, start is accepted on the first cycle.
- board_in=0, start -> done at cycle 21; lines_cleared=0; flash never nonzero; board_out=0.
- Row 19 full, row 18 = bits col0 only, rest 0 (BLINK_CYCLES=4, BLINK_COUNT=2):
  - flash bits 190-199 toggle in 4-cycle on/off phases, 2 pairs.
  - Final board_out has only bit 190 set; lines_cleared=1; done at cycle 1+20+16+20+1=58.
- Rows 19, 17, 16, 14 full; rows 18 and 15 = 10'h155 pattern; rows 0-13 empty:
  - Final rows 19 and 18 = 10'h155 pattern; all other rows 0; lines_cleared=4.
- All 200 bits set -> lines_cleared=20; final board_out=0; FILL runs 20 cycles.
- start pulses during busy with a different board_in -> ignored; result matches the first latched board; one done only.
